control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the ArithmeticLogicUnitSystem datapath. It drives every datapath select and enable to fetch a 16-bit instruction from memory in two byte cycles into the instruction register, then decodes and executes it in one cycle. It sits directly upstream of the datapath: it consumes IROut and FlagsOut and produces all of the datapath's control inputs.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock shared with the datapath.
- Reset  in  1  synchronous, active-low reset.
- IROut  in  16  instruction register contents.
- FlagsOut  in  4  ALU flags {Z,C,N,O}; Z = FlagsOut[3].
- MuxASel, MuxBSel  out  2 each  datapath mux selects.
- MuxCSel  out  1  memory data byte select.
- RF_OutASel, RF_OutBSel, RF_FunSel  out  3 each  register file controls.
- RF_RegSel, RF_ScrSel  out  4 each  register file enables; RF_RegSel[3:0] enables R1..R4 (bit 3 = R1).
- ALU_FunSel  out  5  ALU operation; ALU_WF  out  1  flag write enable.
- ARF_OutCSel, ARF_OutDSel  out  2 each  address register file output selects.
- ARF_FunSel, ARF_RegSel  out  3 each  ARF controls; ARF_RegSel bit 2 = PC, bit 1 = SP, bit 0 = AR.
- IR_LH, IR_Write, Mem_WR, Mem_CS  out  1 each  IR and memory controls. Mem_CS is active-low; Mem_WR=1 means write.
- T  out  4  one-hot state {HALT,T2,T1,T0}.
- Halted  out  1  high in the HALT state.

## Operation
- Inactive defaults: all enables are 0 (RF_RegSel, RF_ScrSel, ARF_RegSel, IR_Write, ALU_WF, Mem_WR), Mem_CS=1, and all selects are 0.
- Encodings:
  - RF/ARF FunSel: 3'b010 = load, 3'b001 = increment, 3'b011 = clear.
  - ARF_OutDSel: 00 = PC, 01 = SP, 10 = AR.
  - Register codes: 2- or 3-bit value, low two bits select 00 = R1 through 11 = R4; bit 2 is ignored.
- While Reset=0, outputs are combinational:
  - RF_FunSel=3'b011 with RF_RegSel=4'hF and RF_ScrSel=4'hF.
  - ARF_FunSel=3'b011 with ARF_RegSel=3'b111.
  - Everything else is at its default.
  - Next state is T0.
- T0, fetch low byte:
  - Mem_CS=0, Mem_WR=0, ARF_OutDSel=00.
  - IR_Write=1, IR_LH=0.
  - ARF_RegSel=3'b100, ARF_FunSel=001 (PC++).
  - Next state T1.
- T1, fetch high byte: same as T0 but IR_LH=1. Next state T2.
- T2, execute. Opcode = IROut[15:10]; format A uses RSel = IROut[9:8] and IMM = IROut[7:0]; format B uses DST = [8:6], S1 = [5:3], S2 = [2:0]. Next state T0 unless noted.
  - 0x00 BRA: MuxBSel=11, ARF_RegSel=100, ARF_FunSel=010 (PC <- IMM).
  - 0x01 BNE: as BRA only if Z=0; otherwise no enables.
  - 0x02 MOVL: MuxASel=11, RF_RegSel=enable(RSel), RF_FunSel=010.
  - 0x03 LD: ARF_OutDSel=10, Mem_CS=0, MuxASel=10, RF_RegSel=enable(RSel), RF_FunSel=010.
  - 0x04 ST: RF_OutASel=RSel, ALU_FunSel=5'b10000 (pass A), MuxCSel=0, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
  - 0x05 to 0x09 (ADD, SUB, AND, ORR, XOR): RF_OutASel=S1, RF_OutBSel=S2, ALU_FunSel = 10100 / 10110 / 10111 / 11000 / 11001 respectively, ALU_WF=1, MuxASel=00, RF_RegSel=enable(DST), RF_FunSel=010.
  - 0x0A MOV: as ADD, but ALU_FunSel=10000 and ALU_WF=0.
  - 0x3F HALT: no enables; next state HALT.
  - Any other opcode: NOP, no enables.
- HALT: all outputs at defaults; the state remains HALT until Reset=0.

## Timing
- The state register updates on the rising edge of Clock. Outputs decode combinationally from the state and IROut.
- Reset is sampled on the Clock edge. Reset=0 in any state, including mid-fetch or HALT, yields T0 on the next edge; T is 4'b0001 after that edge.
- Datapath registers, IR and memory capture on the same edge that advances the state.
- Instruction latency is 3 cycles. The PC advances by 2 per instruction, or is replaced by IMM at the end of T2 for a taken branch.
- BNE samples Z from FlagsOut during T2. Z therefore reflects the last instruction that executed with ALU_WF=1.
- In T0 and T1, IROut is partially stale, but decode must not affect any output in those states.

## Test plan
- Reset then release, with memory[0..1] = 0x02 hex-encoded MOVL R2,#0x5A (IR=16'h095A): T goes 0001 -> 0010 -> 0100 -> 0001; R2=0x005A and PC=2 after cycle 3.
- IR=ADD R1,R2,R3 with R2=3, R3=4: in T2, RF_OutASel=001, RF_OutBSel=010, ALU_FunSel=10100, ALU_WF=1, RF_RegSel=1000; R1=7.
- Two runs with IR=BNE #0x40: with Z=0, PC=0x40 next and T=0001; with Z=1, PC unchanged (2) and no ARF enable.
- IR=ST R4 with AR=0x10, R4=0x00AB: in T2, Mem_CS=0, Mem_WR=1, ARF_OutDSel=10; memory[0x10]=0xAB.
- IR=HALT: Halted=1 and T=1000 held for 10 cycles; a Reset=0 pulse then gives T=0001 and PC=0.
- Reset=0 asserted during T1: the next state is T0, no IR_Write occurs on that edge, and all registers are cleared.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit: two-byte instruction fetch (T0/T1) then one-cycle execute (T2).
// Latency: 3 cycles per instruction; outputs decode combinationally from state and IROut.
// No backpressure: the sequence advances every clock; Reset=0 forces T0 from any state.
`timescale 1ns/1ps
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [3:0]  T,
  output logic        Halted
);

  // One-hot encoding so the state register drives T directly.
  typedef enum logic [3:0] {
    S_T0   = 4'b0001,
    S_T1   = 4'b0010,
    S_T2   = 4'b0100,
    S_HALT = 4'b1000
  } state_t;

  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_CLEAR = 3'b011;

  localparam logic [5:0] OP_BRA  = 6'h00;
  localparam logic [5:0] OP_BNE  = 6'h01;
  localparam logic [5:0] OP_MOVL = 6'h02;
  localparam logic [5:0] OP_LD   = 6'h03;
  localparam logic [5:0] OP_ST   = 6'h04;
  localparam logic [5:0] OP_ADD  = 6'h05;
  localparam logic [5:0] OP_SUB  = 6'h06;
  localparam logic [5:0] OP_AND  = 6'h07;
  localparam logic [5:0] OP_ORR  = 6'h08;
  localparam logic [5:0] OP_XOR  = 6'h09;
  localparam logic [5:0] OP_MOV  = 6'h0A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  state_t state;

  logic [5:0] opcode;
  logic [1:0] rsel;
  logic [1:0] dst;
  logic [1:0] s1;
  logic [1:0] s2;
  logic       z;

  // Instruction fields; bit 2 of each format-B register code selects nothing.
  assign opcode = IROut[15:10];
  assign rsel   = IROut[9:8];
  assign dst    = IROut[7:6];
  assign s1     = IROut[4:3];
  assign s2     = IROut[1:0];
  assign z      = FlagsOut[3];

  // Bits the decoder deliberately ignores.
  logic unused_bits;
  assign unused_bits = ^{FlagsOut[2:0], IROut[8], IROut[5], IROut[2]};

  // Register code 00..11 maps to R1..R4, with R1 on the MSB of the enable.
  function automatic logic [3:0] reg_en(input logic [1:0] code);
    reg_en = 4'b1000 >> code;
  endfunction

  assign T      = state;
  assign Halted = (state == S_HALT);

  // State sequencing: fetch low, fetch high, execute; HALT holds until reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= S_T0;
    end else begin
      case (state)
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= (opcode == OP_HALT) ? S_HALT : S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_T0;
      endcase
    end
  end

  // Control decode from reset, state and (in T2 only) the instruction register.
  always_comb begin
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 3'b000;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    if (!Reset) begin
      RF_FunSel  = FUN_CLEAR;
      RF_RegSel  = 4'hF;
      RF_ScrSel  = 4'hF;
      ARF_FunSel = FUN_CLEAR;
      ARF_RegSel = 3'b111;
    end else begin
      case (state)
        S_T0, S_T1: begin
          // Read byte at PC into the selected IR half, then PC++.
          Mem_CS      = 1'b0;
          ARF_OutDSel = 2'b00;
          IR_Write    = 1'b1;
          IR_LH       = (state == S_T1);
          ARF_RegSel  = 3'b100;
          ARF_FunSel  = FUN_INC;
        end
        S_T2: begin
          case (opcode)
            OP_BRA: begin
              MuxBSel    = 2'b11;
              ARF_RegSel = 3'b100;
              ARF_FunSel = FUN_LOAD;
            end
            OP_BNE: begin
              if (!z) begin
                MuxBSel    = 2'b11;
                ARF_RegSel = 3'b100;
                ARF_FunSel = FUN_LOAD;
              end
            end
            OP_MOVL: begin
              MuxASel   = 2'b11;
              RF_RegSel = reg_en(rsel);
              RF_FunSel = FUN_LOAD;
            end
            OP_LD: begin
              ARF_OutDSel = 2'b10;
              Mem_CS      = 1'b0;
              MuxASel     = 2'b10;
              RF_RegSel   = reg_en(rsel);
              RF_FunSel   = FUN_LOAD;
            end
            OP_ST: begin
              RF_OutASel  = {1'b0, rsel};
              ALU_FunSel  = 5'b10000;
              MuxCSel     = 1'b0;
              ARF_OutDSel = 2'b10;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR, OP_MOV: begin
              RF_OutASel = {1'b0, s1};
              RF_OutBSel = {1'b0, s2};
              ALU_WF     = (opcode != OP_MOV);
              MuxASel    = 2'b00;
              RF_RegSel  = reg_en(dst);
              RF_FunSel  = FUN_LOAD;
              case (opcode)
                OP_ADD:  ALU_FunSel = 5'b10100;
                OP_SUB:  ALU_FunSel = 5'b10110;
                OP_AND:  ALU_FunSel = 5'b10111;
                OP_ORR:  ALU_FunSel = 5'b11000;
                OP_XOR:  ALU_FunSel = 5'b11001;
                default: ALU_FunSel = 5'b10000;
              endcase
            end
            default: begin
              // HALT and undefined opcodes issue no enables.
            end
          endcase
        end
        default: begin
          // HALT state: everything stays at its inactive default.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer with a small behavioural PC / IR / register / memory model.
// Table vectors drive IROut directly; hand sequences run a program from the memory model.
// Expected T2 control words are queued when an instruction starts and compared in T2.
`timescale 1ns/1ps
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  FlagsOut;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [3:0]  T;
  logic        Halted;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
    .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .T(T), .Halted(Halted)
  );

  typedef struct packed {
    logic [1:0] mux_a, mux_b;
    logic       mux_c;
    logic [2:0] oa, ob, rf_fun;
    logic [3:0] rf_reg, rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] arf_c, arf_d;
    logic [2:0] arf_fun, arf_reg;
    logic       ir_lh, ir_write, mem_wr, mem_cs;
  } ctl_t;

  typedef struct {
    logic [15:0] ir;
    logic        z;
    ctl_t        exp;
    logic [3:0]  exp_next;
    string       name;
  } vec_t;

  ctl_t act_ctl;
  assign act_ctl = {MuxASel, MuxBSel, MuxCSel, RF_OutASel, RF_OutBSel, RF_FunSel,
                    RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel,
                    ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS};

  // Datapath model
  logic        use_mem;
  logic        z_drv;
  logic [15:0] ir_drv, ir_mem, pc;
  logic [7:0]  mem [256];
  logic [15:0] r [4];

  assign IROut    = use_mem ? ir_mem : ir_drv;
  assign FlagsOut = {z_drv, 3'b111};

  always @(posedge Clock) begin
    if (ARF_RegSel[2]) begin
      case (ARF_FunSel)
        3'b011:  pc <= 16'h0000;
        3'b001:  pc <= pc + 16'd1;
        3'b010:  if (MuxBSel == 2'b11) pc <= {8'h00, IROut[7:0]};
        default: ;
      endcase
    end
    if (use_mem && IR_Write && !Mem_CS && !Mem_WR && ARF_OutDSel == 2'b00) begin
      if (IR_LH) ir_mem[15:8] <= mem[pc[7:0]];
      else       ir_mem[7:0]  <= mem[pc[7:0]];
    end
    for (int i = 0; i < 4; i++) begin
      if (RF_RegSel[3-i]) begin
        case (RF_FunSel)
          3'b011:  r[i] <= 16'h0000;
          3'b010:  if (MuxASel == 2'b11) r[i] <= {8'h00, IROut[7:0]};
          default: ;
        endcase
      end
    end
  end

  int   checks = 0;
  int   errors = 0;
  ctl_t sb[$];
  vec_t vecs[$];

  function automatic ctl_t c_dflt();
    ctl_t c = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_fetch(input logic lh);
    ctl_t c = c_dflt();
    c.mem_cs = 1'b0; c.ir_write = 1'b1; c.ir_lh = lh;
    c.arf_reg = 3'b100; c.arf_fun = 3'b001;
    return c;
  endfunction

  function automatic ctl_t c_rst();
    ctl_t c = c_dflt();
    c.rf_fun = 3'b011; c.rf_reg = 4'hF; c.rf_scr = 4'hF;
    c.arf_fun = 3'b011; c.arf_reg = 3'b111;
    return c;
  endfunction

  function automatic ctl_t c_br();
    ctl_t c = c_dflt();
    c.mux_b = 2'b11; c.arf_reg = 3'b100; c.arf_fun = 3'b010;
    return c;
  endfunction

  function automatic ctl_t c_movl(input logic [3:0] en);
    ctl_t c = c_dflt();
    c.mux_a = 2'b11; c.rf_reg = en; c.rf_fun = 3'b010;
    return c;
  endfunction

  function automatic ctl_t c_ld(input logic [3:0] en);
    ctl_t c = c_dflt();
    c.arf_d = 2'b10; c.mem_cs = 1'b0; c.mux_a = 2'b10; c.rf_reg = en; c.rf_fun = 3'b010;
    return c;
  endfunction

  function automatic ctl_t c_st(input logic [2:0] oa);
    ctl_t c = c_dflt();
    c.oa = oa; c.alu_fun = 5'b10000; c.arf_d = 2'b10; c.mem_cs = 1'b0; c.mem_wr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_alu(input logic [2:0] oa, input logic [2:0] ob,
                                 input logic [4:0] fn, input logic wf, input logic [3:0] en);
    ctl_t c = c_dflt();
    c.oa = oa; c.ob = ob; c.alu_fun = fn; c.alu_wf = wf;
    c.mux_a = 2'b00; c.rf_reg = en; c.rf_fun = 3'b010;
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic sb_chk(input string name);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_expectation required=queued_entry", name);
    end else begin
      chk({name, "_t2"}, 64'(act_ctl), 64'(sb.pop_front()));
    end
  endtask

  // Runs one instruction from T0: checks both fetch cycles, then the queued T2 word.
  task automatic exec(input string name);
    #1;
    chk({name, "_t0"}, 64'(act_ctl), 64'(c_fetch(1'b0)));
    tick();
    chk({name, "_t1"}, 64'(act_ctl), 64'(c_fetch(1'b1)));
    tick();
    chk({name, "_state_t2"}, 64'(T), 64'(4'b0100));
    sb_chk(name);
    tick();
  endtask

  initial begin
    int held;
    Reset   = 1'b0;
    use_mem = 1'b1;
    ir_drv  = 16'h0000;
    z_drv   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h5A; mem[8'h01] = 8'h09;   // MOVL R2,#0x5A
    mem[8'h02] = 8'h40; mem[8'h03] = 8'h04;   // BNE #0x40 (Z=0, taken)
    mem[8'h40] = 8'h08; mem[8'h41] = 8'h04;   // BNE #0x08 (Z=1, not taken)
    mem[8'h42] = 8'h00; mem[8'h43] = 8'hFC;   // HALT

    // Reset state
    tick();
    chk("rst_ctl", 64'(act_ctl), 64'(c_rst()));
    chk("rst_state", 64'(T), 64'(4'b0001));
    chk("rst_pc", 64'(pc), 64'(16'h0000));
    chk("rst_r2", 64'(r[1]), 64'(16'h0000));
    Reset = 1'b1;

    // MOVL from memory
    sb.push_back(c_movl(4'b0100));
    exec("movl_mem");
    chk("movl_ir", 64'(ir_mem), 64'(16'h095A));
    chk("movl_state", 64'(T), 64'(4'b0001));
    chk("movl_r2", 64'(r[1]), 64'(16'h005A));
    chk("movl_pc", 64'(pc), 64'(16'h0002));

    // BNE taken and not taken
    sb.push_back(c_br());
    exec("bne_taken");
    chk("bne_taken_pc", 64'(pc), 64'(16'h0040));
    chk("bne_taken_state", 64'(T), 64'(4'b0001));
    z_drv = 1'b1;
    sb.push_back(c_dflt());
    exec("bne_not_taken");
    chk("bne_nt_pc", 64'(pc), 64'(16'h0042));

    // HALT holds until reset
    sb.push_back(c_dflt());
    exec("halt");
    chk("halt_state", 64'(T), 64'(4'b1000));
    chk("halt_flag", 64'(Halted), 64'(1'b1));
    held = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (T == 4'b1000 && Halted && act_ctl == c_dflt()) held++;
    end
    chk("halt_hold_cycles", 64'(held), 64'(10));
    chk("halt_pc", 64'(pc), 64'(16'h0044));
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    chk("halt_rst_state", 64'(T), 64'(4'b0001));
    chk("halt_rst_pc", 64'(pc), 64'(16'h0000));
    chk("halt_rst_halted", 64'(Halted), 64'(1'b0));

    // Reset asserted in T1
    tick();
    chk("t1_state", 64'(T), 64'(4'b0010));
    Reset = 1'b0;
    #1;
    chk("t1_rst_ctl", 64'(act_ctl), 64'(c_rst()));
    chk("t1_rst_irwrite", 64'(IR_Write), 64'(1'b0));
    tick();
    chk("t1_rst_state", 64'(T), 64'(4'b0001));
    chk("t1_rst_pc", 64'(pc), 64'(16'h0000));
    chk("t1_rst_r2", 64'(r[1]), 64'(16'h0000));
    chk("t1_rst_ir", 64'(ir_mem), 64'(16'hFC5A));
    Reset = 1'b1;

    // Decode table, IROut driven directly
    vecs.push_back('{16'h0040, 1'b0, c_br(),   4'b0001, "bra"});
    vecs.push_back('{16'h0040, 1'b1, c_br(),   4'b0001, "bra_z1"});
    vecs.push_back('{16'h0440, 1'b0, c_br(),   4'b0001, "bne_z0"});
    vecs.push_back('{16'h0440, 1'b1, c_dflt(), 4'b0001, "bne_z1"});
    vecs.push_back('{16'h095A, 1'b0, c_movl(4'b0100), 4'b0001, "movl_r2"});
    vecs.push_back('{16'h0F33, 1'b0, c_ld(4'b0001),   4'b0001, "ld_r4"});
    vecs.push_back('{16'h0C00, 1'b0, c_ld(4'b1000),   4'b0001, "ld_r1"});
    vecs.push_back('{16'h1300, 1'b0, c_st(3'b011),    4'b0001, "st_r4"});
    vecs.push_back('{16'h140A, 1'b0, c_alu(3'b001, 3'b010, 5'b10100, 1'b1, 4'b1000), 4'b0001, "add"});
    vecs.push_back('{16'h19EB, 1'b0, c_alu(3'b001, 3'b011, 5'b10110, 1'b1, 4'b0001), 4'b0001, "sub"});
    vecs.push_back('{16'h1C53, 1'b0, c_alu(3'b010, 3'b011, 5'b10111, 1'b1, 4'b0100), 4'b0001, "and"});
    vecs.push_back('{16'h2081, 1'b0, c_alu(3'b000, 3'b001, 5'b11000, 1'b1, 4'b0010), 4'b0001, "orr"});
    vecs.push_back('{16'h24D8, 1'b0, c_alu(3'b011, 3'b000, 5'b11001, 1'b1, 4'b0001), 4'b0001, "xor"});
    vecs.push_back('{16'h2818, 1'b0, c_alu(3'b011, 3'b000, 5'b10000, 1'b0, 4'b1000), 4'b0001, "mov"});
    vecs.push_back('{16'h2C00, 1'b0, c_dflt(), 4'b0001, "nop"});

    use_mem = 1'b0;
    foreach (vecs[k]) begin
      ir_drv = vecs[k].ir;
      z_drv  = vecs[k].z;
      sb.push_back(vecs[k].exp);
      exec(vecs[k].name);
      chk({vecs[k].name, "_next"}, 64'(T), 64'(vecs[k].exp_next));
    end
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
